// File: rtl/seq_alu.sv
// Registered WIDTH-bit ALU with valid/ready handshakes,
// status flags and a multi-cycle shift-add multiplier.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, nstate;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  logic             accept;
  logic             last_step;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;

  assign accept    = in_valid && in_ready;
  assign last_step = (state == BUSY) && (cnt == LAST);
  assign sum       = {1'b0, A} + {1'b0, B};
  assign diff      = {1'b0, A} - {1'b0, B};
  assign acc_step  = mplier[0] ? acc + mcand : acc;

  // single-cycle result and flags from the live operands
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    unique case (opcode)
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (A[WIDTH-1] == B[WIDTH-1]) &&
                (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        res   = diff[WIDTH-1:0];
        res_c = diff[WIDTH];
        res_v = (A[WIDTH-1] != B[WIDTH-1]) &&
                (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: res = A & B;
      OP_OR:  res = A | B;
      OP_XOR: res = A ^ B;
      OP_NOT: res = ~A;
      OP_MUL: res = '0;
      OP_SLT: res = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
      default: res = '0;
    endcase
  end

  // next-state and handshake outputs
  always_comb begin
    nstate    = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          nstate = (opcode == OP_MUL) ? BUSY : DONE;
      end
      BUSY: begin
        if (last_step)
          nstate = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= nstate;
  end

  // multiplier datapath: one shift-add step per BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, A};
      mplier <= B;
      cnt    <= '0;
    end else if (state == BUSY) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  // result and flag registers, held outside the load points
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Out      <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept && opcode != OP_MUL) begin
      Out      <= res;
      carry    <= res_c;
      zero     <= (res == '0);
      overflow <= res_v;
    end else if (last_step) begin
      Out      <= acc_step[WIDTH-1:0];
      carry    <= |acc_step[2*WIDTH-1:WIDTH];
      zero     <= (acc_step[WIDTH-1:0] == '0);
      overflow <= 1'b0;
    end
  end

endmodule
